// File: rtl/layer_compositor.sv
// ---------------------------------------------------------------------------
// layer_compositor
//
// Two-stage sprite layer compositor with per-frame collision detection.
// Layer 0 is the player and has the highest drawing priority; lower layer
// index always wins. Each frame, the block records which sprite layers
// overlapped the player and publishes that as a mask at the next frame start.
//
// Optional feature macro: LAYER_COLOR_KEY_EN
//   When defined, a layer pixel whose colour equals KEY_COLOR is treated as
//   not present (transparent) for both compositing and collision detection.
//   When undefined, key-coloured pixels are drawn like any other colour.
//
// Parameters
//   NUM_LAYERS  number of sprite layers (2..8), layer 0 = player
//   RGB_W       pixel colour width
//   KEY_COLOR   transparent colour key (used only with LAYER_COLOR_KEY_EN)
//
// Ports
//   clk             system clock, all state on rising edge
//   reset           asynchronous active-high reset, synchronous release
//   video_off       blanking, forces black output
//   frame_start     one-cycle pulse at start of each frame
//   layer_on        per-layer pixel-present flags
//   layer_rgb       per-layer colour, layer i at [i*RGB_W +: RGB_W]
//   layer_en_in     requested layer enables, taken at frame_start
//   bg_rgb          background colour
//   override_valid  full-screen image select
//   override_rgb    full-screen image pixel
//   rgb_out         composited pixel, 2-cycle latency
//   collide_mask    bit i = layer i overlapped layer 0 in previous frame
//   collide_valid   one-cycle pulse when collide_mask updates
// ---------------------------------------------------------------------------
module layer_compositor #(
    parameter int                NUM_LAYERS = 4,
    parameter int                RGB_W      = 12,
    parameter logic [RGB_W-1:0]  KEY_COLOR  = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          video_off,
    input  logic                          frame_start,
    input  logic [NUM_LAYERS-1:0]         layer_on,
    input  logic [NUM_LAYERS*RGB_W-1:0]   layer_rgb,
    input  logic [NUM_LAYERS-1:0]         layer_en_in,
    input  logic [RGB_W-1:0]              bg_rgb,
    input  logic                          override_valid,
    input  logic [RGB_W-1:0]              override_rgb,
    output logic [RGB_W-1:0]              rgb_out,
    output logic [NUM_LAYERS-1:0]         collide_mask,
    output logic                          collide_valid
);

`ifdef LAYER_COLOR_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    // Active layer enables, updated only at frame boundaries
    logic [NUM_LAYERS-1:0]        r_en_act;

    // Stage 1 registers
    logic [NUM_LAYERS-1:0]        r_eff_on_p1;
    logic [NUM_LAYERS*RGB_W-1:0]  r_layer_rgb_p1;
    logic [RGB_W-1:0]             r_bg_rgb_p1;
    logic                         r_ovr_vld_p1;
    logic [RGB_W-1:0]             r_ovr_rgb_p1;
    logic                         r_video_off_p1;
    logic                         r_frame_start_p1;

    // Stage 2 / output registers
    logic [RGB_W-1:0]             r_rgb_out_p2;
    logic [NUM_LAYERS-1:0]        r_acc;
    logic [NUM_LAYERS-1:0]        r_collide_mask;
    logic                         r_collide_valid;

    logic [NUM_LAYERS-1:0]        w_en_now;
    logic [NUM_LAYERS-1:0]        w_key_ok;
    logic [NUM_LAYERS-1:0]        w_eff_on;
    logic [RGB_W-1:0]             w_pick_rgb;
    logic [RGB_W-1:0]             w_rgb_next;
    logic [NUM_LAYERS-1:0]        w_contrib;

    // A new enable set presented with frame_start applies to that same pixel,
    // so bypass the register on the boundary cycle.
    assign w_en_now = frame_start ? layer_en_in : r_en_act;

    always_comb begin
        w_key_ok = '1;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (KEY_EN && (layer_rgb[i*RGB_W +: RGB_W] == KEY_COLOR)) begin
                w_key_ok[i] = 1'b0;
            end
        end
    end

    assign w_eff_on = layer_on & w_en_now & w_key_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en_act <= '1;
        end else if (frame_start) begin
            r_en_act <= layer_en_in;
        end
    end

    // ---- Stage 1: effective layer flags and pixel data ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_eff_on_p1      <= '0;
            r_layer_rgb_p1   <= '0;
            r_bg_rgb_p1      <= '0;
            r_ovr_vld_p1     <= 1'b0;
            r_ovr_rgb_p1     <= '0;
            r_video_off_p1   <= 1'b0;
            r_frame_start_p1 <= 1'b0;
        end else begin
            r_eff_on_p1      <= w_eff_on;
            r_layer_rgb_p1   <= layer_rgb;
            r_bg_rgb_p1      <= bg_rgb;
            r_ovr_vld_p1     <= override_valid;
            r_ovr_rgb_p1     <= override_rgb;
            r_video_off_p1   <= video_off;
            r_frame_start_p1 <= frame_start;
        end
    end

    // Priority select: scan from the top so the lowest present index wins.
    always_comb begin
        w_pick_rgb = r_bg_rgb_p1;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (r_eff_on_p1[i]) begin
                w_pick_rgb = r_layer_rgb_p1[i*RGB_W +: RGB_W];
            end
        end
    end

    always_comb begin
        if (r_video_off_p1) begin
            w_rgb_next = '0;
        end else if (r_ovr_vld_p1) begin
            w_rgb_next = r_ovr_rgb_p1;
        end else begin
            w_rgb_next = w_pick_rgb;
        end
    end

    // Overlap with the player only counts on visible, non-override pixels.
    // Bit 0 is never set: the player cannot collide with itself.
    always_comb begin
        w_contrib = '0;
        if (!r_video_off_p1 && !r_ovr_vld_p1) begin
            for (int i = 1; i < NUM_LAYERS; i++) begin
                w_contrib[i] = r_eff_on_p1[0] & r_eff_on_p1[i];
            end
        end
    end

    // ---- Stage 2: composited pixel and collision accumulation ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb_out_p2    <= '0;
            r_acc           <= '0;
            r_collide_mask  <= '0;
            r_collide_valid <= 1'b0;
        end else begin
            r_rgb_out_p2 <= w_rgb_next;
            if (r_frame_start_p1) begin
                // Publish the finished frame; the boundary pixel starts the new one.
                r_collide_mask  <= r_acc;
                r_acc           <= w_contrib;
                r_collide_valid <= 1'b1;
            end else begin
                r_acc           <= r_acc | w_contrib;
                r_collide_valid <= 1'b0;
            end
        end
    end

    assign rgb_out       = r_rgb_out_p2;
    assign collide_mask  = r_collide_mask;
    assign collide_valid = r_collide_valid;

endmodule
